wb_arbiter_2x1: RTL and testbench
=================================

WB_ARBITER_2X1 -- requirements
Module: wb_arbiter_2x1

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: cycles a grant may go without ack before abort; legal range 2..65535; used only when WB_ARB_TIMEOUT_EN is defined.
REQ-002 Port clk_i, input, 1: single clock; all state changes on the rising edge.
REQ-003 Port rstn_i, input, 1: reset; asynchronous assertion, active-low.
REQ-004 Port m0_wb, wishbone_if.SLAVE: requester 0, the core data master; signals cyc, stb, we, sel[3:0], addr[31:0], wdata[31:0], rdata[31:0], ack, err, stall.
REQ-005 Port m1_wb, wishbone_if.SLAVE: requester 1, the test-harness loader/signature master; same signal set as m0_wb.
REQ-006 Port s_wb, wishbone_if.MASTER: the shared memory data port.
REQ-007 Port grant_o, output, 2: one-hot current grant, bit0 = m0, bit1 = m1; 00 = none.

Function
REQ-008 FSM states: IDLE, GNT0, GNT1; grant_o is decoded from the registered state.
REQ-009 IDLE, only one master's cyc high: enter that master's GNT state at the next edge.
REQ-010 IDLE, both cyc high: grant the master not granted last (round-robin on a 1-bit last_grant register).
REQ-011 IDLE, neither cyc high: stay in IDLE.
REQ-012 Arbitration latency: a cyc first seen in IDLE at edge N is granted at edge N+1; slave sees stb no earlier than the cycle after edge N+1.
REQ-013 GNTx is held while master x keeps cyc high, regardless of the other master's requests; no preemption.
REQ-014 GNTx, master x drops cyc: go to IDLE at the next edge; re-arbitration takes one extra cycle.
REQ-015 Granted master: s_wb cyc, stb, we, sel, addr, wdata driven combinationally from it; its rdata, ack, err, stall driven from s_wb.
REQ-016 Non-granted master: ack = 0, err = 0, stall = 1, rdata = 0.
REQ-017 IDLE: s_wb cyc = 0, stb = 0, we = 0; both masters see stall = 1.
REQ-018 An ack arriving in the same cycle as the granted master's cyc fall is still forwarded to that master.
REQ-019 An outstanding counter (stb & !stall increments, ack/err decrements, 8 bits, saturating) is kept for the timeout and for debug; it resets to 0 on every state change.

Reset
REQ-020 rstn_i low forces at once: state IDLE; last_grant = 1 (m0 wins the first tie); outstanding = 0; timeout count = 0; grant_o = 00.
REQ-021 Reset asserted mid-transaction: s_wb cyc/stb drop combinationally in the same cycle; the pending access is discarded with no ack or err to any master.
REQ-022 First arbitration after reset release happens at the first rising edge with rstn_i high.

Configuration
REQ-023 Macro WB_ARB_TIMEOUT_EN defined: a 16-bit counter runs in GNTx, clearing on each ack; reaching TIMEOUT_CYCLES pulses err to master x for 1 cycle, forces s_wb cyc low, and returns to IDLE.
REQ-024 Macro WB_ARB_TIMEOUT_EN undefined: no counter is instantiated; err is a pure pass-through from s_wb; a grant may be held indefinitely.

Verification
REQ-025 Bench: m0 only, single read addr 0x100 -> grant_o=01 one cycle after cyc; m0 gets ack with mem[0x40] data; IDLE one cycle after cyc drops.
REQ-026 Bench: m0 and m1 raise cyc in the same cycle right after reset -> m0 granted first; after m0 drops cyc, m1 granted 2 cycles later (IDLE bubble).
REQ-027 Bench: m1 burst of 4 pipelined writes while m0 requests -> m0 stall=1 throughout; m1 receives 4 acks; m0 granted only after m1 cyc falls.
REQ-028 Bench: back-to-back contention for 6 rounds -> grants alternate 01,10,01,10,01,10.
REQ-029 Bench: rstn_i pulled low while m0 write in flight -> s_wb cyc=0 same cycle; grant_o=00; no ack to m0; m0 wins next tie.
REQ-030 Bench, WB_ARB_TIMEOUT_EN defined with TIMEOUT_CYCLES=8 and the slave stuck without ack -> m0 err pulse exactly 8 cycles after grant; state IDLE the next cycle.

Source files
------------

// File: rtl/wb_arbiter_2x1_if.sv
// Wishbone pipelined bus bundle shared by the arbiter and its bench.
// MASTER drives the request side; SLAVE drives the response side.
interface wishbone_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic        stall;

    modport MASTER (
        output cyc, stb, we, sel, addr, wdata,
        input  rdata, ack, err, stall
    );

    modport SLAVE (
        input  cyc, stb, we, sel, addr, wdata,
        output rdata, ack, err, stall
    );
endinterface

// File: rtl/wb_arbiter_2x1.sv
// Two-master round-robin Wishbone arbiter onto a single shared slave port.
// Optional grant watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter_2x1 #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    wishbone_if.SLAVE   m0_wb,
    wishbone_if.SLAVE   m1_wb,
    wishbone_if.MASTER  s_wb,
    output logic [1:0]  grant_o,
    output logic [7:0]  outstanding_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t      state_reg;
    logic [1:0]  grant_reg;
    logic        last_grant_reg;
    logic [7:0]  outstanding_reg;

    logic        gnt0;
    logic        gnt1;
    logic        pick_m0;
    logic        release_grant;
    logic        state_change;
    logic        timeout_hit;
    logic        beat_issue;
    logic        beat_done;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
        $error("wb_arbiter_2x1: TIMEOUT_CYCLES must be within 2..65535");
    end

    assign gnt0    = grant_reg[0];
    assign gnt1    = grant_reg[1];
    assign grant_o = grant_reg;

    // last_grant_reg = 1 means m1 was served last, so m0 wins the next tie.
    assign pick_m0       = m0_wb.cyc & (~m1_wb.cyc | last_grant_reg);
    assign release_grant = (gnt0 & ~m0_wb.cyc) | (gnt1 & ~m1_wb.cyc) | timeout_hit;
    assign state_change  = ((state_reg == IDLE) & (m0_wb.cyc | m1_wb.cyc)) | release_grant;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg      <= IDLE;
            grant_reg      <= 2'b00;
            last_grant_reg <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_m0) begin
                        state_reg      <= GNT0;
                        grant_reg      <= 2'b01;
                        last_grant_reg <= 1'b0;
                    end else if (m1_wb.cyc) begin
                        state_reg      <= GNT1;
                        grant_reg      <= 2'b10;
                        last_grant_reg <= 1'b1;
                    end
                end
                GNT0, GNT1: begin
                    if (release_grant) begin
                        state_reg <= IDLE;
                        grant_reg <= 2'b00;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    grant_reg <= 2'b00;
                end
            endcase
        end
    end

    // Request path: a timeout abort pulls cyc/stb low for its single cycle.
    assign s_wb.cyc   = gnt0 ? (m0_wb.cyc & ~timeout_hit) :
                        gnt1 ? (m1_wb.cyc & ~timeout_hit) : 1'b0;
    assign s_wb.stb   = gnt0 ? (m0_wb.stb & ~timeout_hit) :
                        gnt1 ? (m1_wb.stb & ~timeout_hit) : 1'b0;
    assign s_wb.we    = gnt0 ? m0_wb.we    : gnt1 ? m1_wb.we    : 1'b0;
    assign s_wb.sel   = gnt0 ? m0_wb.sel   : gnt1 ? m1_wb.sel   : 4'h0;
    assign s_wb.addr  = gnt0 ? m0_wb.addr  : gnt1 ? m1_wb.addr  : 32'h0;
    assign s_wb.wdata = gnt0 ? m0_wb.wdata : gnt1 ? m1_wb.wdata : 32'h0;

    assign m0_wb.rdata = gnt0 ? s_wb.rdata : 32'h0;
    assign m0_wb.ack   = gnt0 & s_wb.ack;
    assign m0_wb.err   = gnt0 & (s_wb.err | timeout_hit);
    assign m0_wb.stall = gnt0 ? s_wb.stall : 1'b1;

    assign m1_wb.rdata = gnt1 ? s_wb.rdata : 32'h0;
    assign m1_wb.ack   = gnt1 & s_wb.ack;
    assign m1_wb.err   = gnt1 & (s_wb.err | timeout_hit);
    assign m1_wb.stall = gnt1 ? s_wb.stall : 1'b1;

    assign beat_issue = s_wb.cyc & s_wb.stb & ~s_wb.stall;
    assign beat_done  = (gnt0 | gnt1) & (s_wb.ack | s_wb.err);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            outstanding_reg <= 8'd0;
        end else if (state_change) begin
            outstanding_reg <= 8'd0;
        end else if (beat_issue && !beat_done && outstanding_reg != 8'hFF) begin
            outstanding_reg <= outstanding_reg + 8'd1;
        end else if (!beat_issue && beat_done && outstanding_reg != 8'h00) begin
            outstanding_reg <= outstanding_reg - 8'd1;
        end
    end

    assign outstanding_o = outstanding_reg;

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt_reg;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tmo_cnt_reg <= 16'd0;
        end else if (state_change || !(gnt0 || gnt1) || s_wb.ack) begin
            tmo_cnt_reg <= 16'd0;
        end else if (!timeout_hit) begin
            tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
        end
    end

    // Counter equals cycles elapsed since the grant edge (or the last ack).
    assign timeout_hit = (gnt0 | gnt1) & (tmo_cnt_reg == 16'(TIMEOUT_CYCLES));
`else
    assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter_2x1.sv
// Directed bench for wb_arbiter_2x1 with a one-cycle-latency pipelined memory slave.
// Define WB_ARB_TIMEOUT_EN on both RTL and bench to exercise the watchdog.
module tb_wb_arbiter_2x1;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [1:0]  grant;
    logic [7:0]  outstanding;
    logic        slave_stuck = 1'b0;
    logic [31:0] mem [256];
    int          checks = 0;
    int          errors = 0;

    wishbone_if m0_if ();
    wishbone_if m1_if ();
    wishbone_if s_if ();

    wb_arbiter_2x1 #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .m0_wb         (m0_if),
        .m1_wb         (m1_if),
        .s_wb          (s_if),
        .grant_o       (grant),
        .outstanding_o (outstanding)
    );

    always #5 clk = ~clk;

    assign s_if.stall = 1'b0;
    assign s_if.err   = 1'b0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_if.ack   <= 1'b0;
            s_if.rdata <= 32'h0;
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + 32'(i);
        end else begin
            s_if.ack   <= s_if.cyc && s_if.stb && !slave_stuck;
            s_if.rdata <= mem[s_if.addr[9:2]];
            if (s_if.cyc && s_if.stb && s_if.we) mem[s_if.addr[9:2]] <= s_if.wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_masters();
        m0_if.cyc = 0; m0_if.stb = 0; m0_if.we = 0; m0_if.sel = 4'hF;
        m0_if.addr = 32'h0; m0_if.wdata = 32'h0;
        m1_if.cyc = 0; m1_if.stb = 0; m1_if.we = 0; m1_if.sel = 4'hF;
        m1_if.addr = 32'h0; m1_if.wdata = 32'h0;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        idle_masters();
        #2 rstn = 1'b0;
        tick();
        tick();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant); end
        checks++; if (s_if.cyc !== 1'b0) begin errors++; $display("FAIL reset_s_cyc: got %b want 0", s_if.cyc); end
        checks++; if ({m1_if.stall, m0_if.stall} !== 2'b11) begin errors++; $display("FAIL reset_stall: got %b want 11", {m1_if.stall, m0_if.stall}); end
        checks++; if (outstanding !== 8'd0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
        checks++; if (m0_if.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", m0_if.rdata); end
        rstn = 1'b1;
        $display("reset: grant=%b s_cyc=%b", grant, s_if.cyc);
    endtask

    task automatic test_single_read();
        m0_if.cyc = 1; m0_if.stb = 1; m0_if.we = 0; m0_if.addr = 32'h100;
        #1;
        checks++; if (grant !== 2'b00 || s_if.stb !== 1'b0) begin errors++; $display("FAIL read_latency: got grant=%b stb=%b want 00/0", grant, s_if.stb); end
        tick();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL read_grant: got %b want 01", grant); end
        checks++; if (s_if.cyc !== 1'b1 || s_if.stb !== 1'b1 || s_if.addr !== 32'h100) begin errors++; $display("FAIL read_fwd: got cyc=%b stb=%b addr=%h want 1/1/100", s_if.cyc, s_if.stb, s_if.addr); end
        tick();
        m0_if.stb = 0; m0_if.cyc = 0;
        #1;
        checks++; if (m0_if.ack !== 1'b1) begin errors++; $display("FAIL read_ack_on_cyc_fall: got %b want 1", m0_if.ack); end
        checks++; if (m0_if.rdata !== 32'hA000_0040) begin errors++; $display("FAIL read_data: got %h want a0000040", m0_if.rdata); end
        checks++; if (outstanding !== 8'd1) begin errors++; $display("FAIL read_outstanding: got %0d want 1", outstanding); end
        tick();
        checks++; if (grant !== 2'b00 || m0_if.stall !== 1'b1) begin errors++; $display("FAIL read_idle: got grant=%b stall=%b want 00/1", grant, m0_if.stall); end
        checks++; if (outstanding !== 8'd0) begin errors++; $display("FAIL read_outstanding_clear: got %0d want 0", outstanding); end
        $display("single_read: rdata=%h grant=%b", m0_if.rdata, grant);
    endtask

    task automatic test_tie_after_reset();
        idle_masters();
        apply_reset();
        m0_if.cyc = 1; m1_if.cyc = 1;
        tick();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL tie_first: got %b want 01", grant); end
        checks++; if (m1_if.stall !== 1'b1) begin errors++; $display("FAIL tie_m1_stall: got %b want 1", m1_if.stall); end
        tick(); tick();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL tie_hold: got %b want 01", grant); end
        m0_if.cyc = 0;
        tick();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL tie_bubble: got %b want 00", grant); end
        tick();
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL tie_second: got %b want 10", grant); end
        m1_if.cyc = 0;
        tick();
        $display("tie_after_reset: final grant=%b", grant);
    endtask

    task automatic test_burst();
        int acks = 0;
        m1_if.cyc = 1;
        tick();
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL burst_grant: got %b want 10", grant); end
        m0_if.cyc = 1; m0_if.stb = 1; m0_if.addr = 32'h100;
        m1_if.stb = 1; m1_if.we = 1;
        for (int i = 0; i < 4; i++) begin
            m1_if.addr  = 32'h200 + 32'(4 * i);
            m1_if.wdata = 32'h5A5A_0000 + 32'(i);
            #1;
            checks++; if (m0_if.stall !== 1'b1) begin errors++; $display("FAIL burst_m0_stall%0d: got %b want 1", i, m0_if.stall); end
            tick();
            if (m1_if.ack === 1'b1) acks++;
        end
        m1_if.stb = 0; m1_if.we = 0; m1_if.cyc = 0;
        #1;
        checks++; if (acks != 4) begin errors++; $display("FAIL burst_acks: got %0d want 4", acks); end
        checks++; if (mem[8'h83] !== 32'h5A5A_0003 || mem[8'h80] !== 32'h5A5A_0000) begin errors++; $display("FAIL burst_mem: got %h/%h want 5a5a0000/5a5a0003", mem[8'h80], mem[8'h83]); end
        tick();
        checks++; if (grant !== 2'b00 || m0_if.stall !== 1'b1) begin errors++; $display("FAIL burst_bubble: got grant=%b stall=%b want 00/1", grant, m0_if.stall); end
        tick();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL burst_m0_after: got %b want 01", grant); end
        m0_if.cyc = 0; m0_if.stb = 0;
        tick();
        $display("burst: acks=%0d grant=%b", acks, grant);
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_grant [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        idle_masters();
        apply_reset();
        for (int r = 0; r < 6; r++) begin
            m0_if.cyc = 1; m1_if.cyc = 1;
            tick();
            checks++; if (grant !== exp_grant[r]) begin errors++; $display("FAIL b2b_round%0d: got %b want %b", r, grant, exp_grant[r]); end
            $display("back_to_back: round %0d grant=%b", r, grant);
            m0_if.cyc = 0; m1_if.cyc = 0;
            tick();
        end
    endtask

    task automatic test_reset_mid_write();
        m0_if.cyc = 1; m0_if.stb = 1; m0_if.we = 1;
        m0_if.addr = 32'h300; m0_if.wdata = 32'hDEAD_BEEF;
        tick();
        checks++; if (s_if.cyc !== 1'b1 || grant !== 2'b01) begin errors++; $display("FAIL rst_pre: got cyc=%b grant=%b want 1/01", s_if.cyc, grant); end
        rstn = 1'b0;
        #1;
        checks++; if (s_if.cyc !== 1'b0 || s_if.stb !== 1'b0) begin errors++; $display("FAIL rst_cyc_drop: got cyc=%b stb=%b want 0/0", s_if.cyc, s_if.stb); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b want 00", grant); end
        tick();
        checks++; if (m0_if.ack !== 1'b0 || m0_if.err !== 1'b0) begin errors++; $display("FAIL rst_no_resp: got ack=%b err=%b want 0/0", m0_if.ack, m0_if.err); end
        idle_masters();
        rstn = 1'b1;
        m0_if.cyc = 1; m1_if.cyc = 1;
        tick();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rst_next_tie: got %b want 01", grant); end
        idle_masters();
        tick();
        $display("reset_mid_write: s_cyc=%b grant=%b", s_if.cyc, grant);
    endtask

`ifdef WB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        slave_stuck = 1'b1;
        m0_if.cyc = 1; m0_if.stb = 1; m0_if.addr = 32'h100;
        tick();
        checks++; if (grant !== 2'b01 || m0_if.err !== 1'b0) begin errors++; $display("FAIL tmo_grant: got grant=%b err=%b want 01/0", grant, m0_if.err); end
        for (int k = 1; k < 8; k++) begin
            tick();
            m0_if.stb = 0;
            checks++; if ({m0_if.err, grant} !== 3'b001) begin errors++; $display("FAIL tmo_wait%0d: got err,grant=%b want 001", k, {m0_if.err, grant}); end
        end
        tick();
        checks++; if (m0_if.err !== 1'b1 || s_if.cyc !== 1'b0) begin errors++; $display("FAIL tmo_pulse: got err=%b s_cyc=%b want 1/0", m0_if.err, s_if.cyc); end
        m0_if.cyc = 0;
        tick();
        checks++; if (grant !== 2'b00 || m0_if.err !== 1'b0) begin errors++; $display("FAIL tmo_idle: got grant=%b err=%b want 00/0", grant, m0_if.err); end
        slave_stuck = 1'b0;
        $display("timeout: grant=%b after abort", grant);
    endtask
`else
    task automatic test_no_timeout();
        slave_stuck = 1'b1;
        m0_if.cyc = 1; m0_if.stb = 1; m0_if.addr = 32'h100;
        tick();
        m0_if.stb = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++; if ({m0_if.err, grant} !== 3'b001) begin errors++; $display("FAIL hold_cycle%0d: got err,grant=%b want 001", k, {m0_if.err, grant}); end
        end
        m0_if.cyc = 0;
        tick();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL hold_release: got %b want 00", grant); end
        slave_stuck = 1'b0;
        $display("no_timeout: grant held 20 cycles, then %b", grant);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_tie_after_reset();
        test_burst();
        test_back_to_back();
        test_reset_mid_write();
`ifdef WB_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
